rfphoenix_branch_arb: RTL and testbench

- Shares one branch-condition evaluator among NTHR hardware threads.
- Each thread presents a pending Bcc with two operands and a target PC.
- Round-robin arbiter grants one request per cycle. A two-stage pipeline (operand register, result register) evaluates the condition and returns taken / target / thread id to fetch-redirect logic.
- Sits between the per-thread issue queues and the PC-redirect mux.

---
 rtl/rfphoenix_pkg.sv | 26 ++
 rtl/rfphoenix_bcc_cond.sv | 48 ++++
 rtl/rfphoenix_branch_arb.sv | 189 ++++++++++++++++++
 tb/tb_rfphoenix_branch_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rfphoenix_pkg.sv
// rfphoenix_pkg: shared constants for the branch arbiter slice.
//   - OPC_BCC      : opcode value of the conditional branch (Bcc).
//   - cnd_e        : br.cnd condition codes.
//   - OPC_*/CND_*  : bit offsets and widths of the opcode and br.cnd fields
//                    inside an instruction word.
package rfphoenix_pkg;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 6;
    localparam int CND_LSB = 6;
    localparam int CND_W   = 3;

    localparam logic [OPC_W-1:0] OPC_BCC = 6'h1d;

    typedef enum logic [CND_W-1:0] {
        CND_LT  = 3'd0,
        CND_GE  = 3'd1,
        CND_LE  = 3'd2,
        CND_GT  = 3'd3,
        CND_RS4 = 3'd4,
        CND_RS5 = 3'd5,
        CND_EQ  = 3'd6,
        CND_NE  = 3'd7
    } cnd_e;

endpackage

// File: rtl/rfphoenix_bcc_cond.sv
// rfphoenix_bcc_cond: combinational branch-condition evaluator.
// Ports:
//   ir_i    [INSW] instruction word (opcode + br.cnd fields decoded here)
//   a_i     [VALW] operand a (two's complement)
//   b_i     [VALW] operand b (two's complement)
//   taken_o        1 when the instruction is a Bcc and its condition holds
module rfphoenix_bcc_cond
    import rfphoenix_pkg::*;
#(
    parameter int VALW = 32,
    parameter int INSW = 40
) (
    input  logic [INSW-1:0] ir_i,
    input  logic [VALW-1:0] a_i,
    input  logic [VALW-1:0] b_i,
    output logic            taken_o
);

    logic signed [VALW-1:0] a_s;
    logic signed [VALW-1:0] b_s;
    logic [OPC_W-1:0]       opc;
    cnd_e                   cnd;
    logic                   unused_ir;

    assign a_s = a_i;
    assign b_s = b_i;
    assign opc = ir_i[OPC_LSB +: OPC_W];
    assign cnd = cnd_e'(ir_i[CND_LSB +: CND_W]);

    // Only the opcode and br.cnd fields matter here.
    assign unused_ir = ^ir_i;

    always_comb begin
        taken_o = 1'b0;
        if (opc == OPC_BCC) begin
            case (cnd)
                CND_LT:  taken_o = (a_s <  b_s);
                CND_GE:  taken_o = (a_s >= b_s);
                CND_LE:  taken_o = (a_s <= b_s);
                CND_GT:  taken_o = (a_s >  b_s);
                CND_EQ:  taken_o = (a_s == b_s);
                CND_NE:  taken_o = (a_s != b_s);
                default: taken_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rfphoenix_branch_arb.sv
// rfphoenix_branch_arb: round-robin arbiter sharing one Bcc evaluator among
// NTHR threads, followed by a two-stage pipeline (S1 operand register, output
// result register). Latency is 2 cycles from grant; 1 result per cycle.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_i   [NTHR]     per-thread request valid (held until granted)
//   ir_i/a_i/b_i/tgt_i per-thread instruction, operands, target (slice t = thread t)
//   flush_i [NTHR]     per-thread kill of in-flight and new branches
//   gnt_o   [NTHR]     one-hot grant, combinational
//   res_v_o/res_rdy_i  result valid/ready handshake
//   res_thr_o, res_taken_o, res_tgt_o  result thread id, condition, target
// Optional feature macro RFPHOENIX_BRANCH_STATS_EN adds stat_taken_o and
// stat_ntaken_o, 32-bit wrapping counters of transferred results by taken.
module rfphoenix_branch_arb
    import rfphoenix_pkg::*;
#(
    parameter int  NTHR = 4,
    parameter int  VALW = 32,
    parameter int  INSW = 40,
    parameter int  PCW  = 32,
    localparam int TW   = $clog2(NTHR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NTHR-1:0]      req_i,
    input  logic [NTHR*INSW-1:0] ir_i,
    input  logic [NTHR*VALW-1:0] a_i,
    input  logic [NTHR*VALW-1:0] b_i,
    input  logic [NTHR*PCW-1:0]  tgt_i,
    output logic [NTHR-1:0]      gnt_o,
    input  logic [NTHR-1:0]      flush_i,
    output logic                 res_v_o,
    input  logic                 res_rdy_i,
    output logic [TW-1:0]        res_thr_o,
    output logic                 res_taken_o,
    output logic [PCW-1:0]       res_tgt_o
`ifdef RFPHOENIX_BRANCH_STATS_EN
    ,
    output logic [31:0]          stat_taken_o,
    output logic [31:0]          stat_ntaken_o
`endif
);

    function automatic logic [TW-1:0] rr_idx(input logic [TW-1:0] base, input int off);
        return TW'((int'(base) + off) % NTHR);
    endfunction

    logic [NTHR-1:0] elig;
    logic            advance;
    logic            gnt_any;
    logic            gnt_fire;
    logic [TW-1:0]   gnt_idx;
    logic [TW-1:0]   ptr_q, ptr_d;
    logic            taken_p1;

    logic            vld_p1_q, vld_p1_d;
    logic [TW-1:0]   thr_p1_q, thr_p1_d;
    logic [INSW-1:0] ir_p1_q, ir_p1_d;
    logic [VALW-1:0] a_p1_q, a_p1_d;
    logic [VALW-1:0] b_p1_q, b_p1_d;
    logic [PCW-1:0]  tgt_p1_q, tgt_p1_d;

    logic            vld_p2_q, vld_p2_d;
    logic [TW-1:0]   thr_p2_q, thr_p2_d;
    logic            taken_p2_q, taken_p2_d;
    logic [PCW-1:0]  tgt_p2_q, tgt_p2_d;

    assign elig    = req_i & ~flush_i;
    assign advance = ~vld_p2_q | res_rdy_i;

    // Round-robin picker: first eligible thread at or after ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NTHR; i++) begin
            if (!gnt_any && elig[rr_idx(ptr_q, i)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(ptr_q, i);
            end
        end
    end

    assign gnt_fire = gnt_any & advance & ~rst;
    assign gnt_o    = gnt_fire ? (NTHR'(1) << gnt_idx) : '0;

    // Stage p0 -> p1: grant captures the winning thread into S1.
    always_comb begin
        ptr_d    = gnt_fire ? rr_idx(gnt_idx, 1) : ptr_q;
        vld_p1_d = advance ? gnt_fire : (vld_p1_q & ~flush_i[thr_p1_q]);
        thr_p1_d = thr_p1_q;
        ir_p1_d  = ir_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        tgt_p1_d = tgt_p1_q;
        if (gnt_fire) begin
            thr_p1_d = gnt_idx;
            ir_p1_d  = ir_i[gnt_idx*INSW +: INSW];
            a_p1_d   = a_i[gnt_idx*VALW +: VALW];
            b_p1_d   = b_i[gnt_idx*VALW +: VALW];
            tgt_p1_d = tgt_i[gnt_idx*PCW +: PCW];
        end
    end

    rfphoenix_bcc_cond #(
        .VALW (VALW),
        .INSW (INSW)
    ) u_cond (
        .ir_i    (ir_p1_q),
        .a_i     (a_p1_q),
        .b_i     (b_p1_q),
        .taken_o (taken_p1)
    );

    // Stage p1 -> p2: evaluated result registered into the output stage.
    // A flushed S1 entry moves forward but arrives invalid.
    always_comb begin
        vld_p2_d   = advance ? (vld_p1_q & ~flush_i[thr_p1_q])
                             : (vld_p2_q & ~flush_i[thr_p2_q]);
        thr_p2_d   = thr_p2_q;
        taken_p2_d = taken_p2_q;
        tgt_p2_d   = tgt_p2_q;
        if (advance && vld_p1_q) begin
            thr_p2_d   = thr_p1_q;
            taken_p2_d = taken_p1;
            tgt_p2_d   = tgt_p1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            thr_p2_q   <= '0;
            taken_p2_q <= 1'b0;
            tgt_p2_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            thr_p2_q   <= thr_p2_d;
            taken_p2_q <= taken_p2_d;
            tgt_p2_q   <= tgt_p2_d;
        end
    end

    // S1 payload is qualified by vld_p1_q, so it needs no reset.
    always_ff @(posedge clk) begin
        thr_p1_q <= thr_p1_d;
        ir_p1_q  <= ir_p1_d;
        a_p1_q   <= a_p1_d;
        b_p1_q   <= b_p1_d;
        tgt_p1_q <= tgt_p1_d;
    end

    assign res_v_o     = vld_p2_q;
    assign res_thr_o   = thr_p2_q;
    assign res_taken_o = taken_p2_q;
    assign res_tgt_o   = tgt_p2_q;

`ifdef RFPHOENIX_BRANCH_STATS_EN
    logic        xfer;
    logic [31:0] stat_taken_q, stat_taken_d;
    logic [31:0] stat_ntaken_q, stat_ntaken_d;

    assign xfer = vld_p2_q & res_rdy_i;

    always_comb begin
        stat_taken_d  = stat_taken_q;
        stat_ntaken_d = stat_ntaken_q;
        if (xfer && taken_p2_q)  stat_taken_d  = stat_taken_q + 32'd1;
        if (xfer && !taken_p2_q) stat_ntaken_d = stat_ntaken_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_taken_q  <= '0;
            stat_ntaken_q <= '0;
        end else begin
            stat_taken_q  <= stat_taken_d;
            stat_ntaken_q <= stat_ntaken_d;
        end
    end

    assign stat_taken_o  = stat_taken_q;
    assign stat_ntaken_o = stat_ntaken_q;
`endif

endmodule

// File: tb/tb_rfphoenix_branch_arb.sv
// Directed testbench for rfphoenix_branch_arb (default build, NTHR=4).
module tb_rfphoenix_branch_arb;
    import rfphoenix_pkg::*;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [159:0] ir;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] tgt;
    logic [3:0]   gnt;
    logic [3:0]   flush;
    logic         res_v;
    logic         rdy;
    logic [1:0]   res_thr;
    logic         res_taken;
    logic [31:0]  res_tgt;

    int npass = 0;
    int total = 0;
    int rot_taken [4] = '{1, 0, 1, 0};
    int cc_exp    [9] = '{0, 1, 1, 0, 0, 0, 1, 0, 0};

    rfphoenix_branch_arb dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .ir_i        (ir),
        .a_i         (a),
        .b_i         (b),
        .tgt_i       (tgt),
        .gnt_o       (gnt),
        .flush_i     (flush),
        .res_v_o     (res_v),
        .res_rdy_i   (rdy),
        .res_thr_o   (res_thr),
        .res_taken_o (res_taken),
        .res_tgt_o   (res_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] mk_ir(input logic [5:0] opc, input logic [2:0] cnd);
        logic [39:0] x;
        x = '0;
        x[OPC_LSB +: OPC_W] = opc;
        x[CND_LSB +: CND_W] = cnd;
        return x;
    endfunction

    task automatic set_thr(input int t, input logic [2:0] cnd, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] tv);
        ir[t*40 +: 40]  = mk_ir(OPC_BCC, cnd);
        a[t*32 +: 32]   = av;
        b[t*32 +: 32]   = bv;
        tgt[t*32 +: 32] = tv;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; flush = '0; rdy = 1'b0;
        ir = '0; a = '0; b = '0; tgt = '0;

        // Reset state; requests are ignored while rst is high.
        step();
        req = 4'hF;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_resv", res_v, 0);
        chk("rst_thr", res_thr, 0);
        chk("rst_taken", res_taken, 0);
        chk("rst_tgt", res_tgt, 0);
        req = '0;
        step();
        rst = 1'b0;
        step();

        // Single request, cond LT, -5 < 3.
        set_thr(2, 3'd0, -32'sd5, 32'd3, 32'h2000_0042);
        rdy = 1'b1;
        req = 4'b0100;
        #1;
        chk("single_gnt", gnt, 4'b0100);
        step();
        req = '0;
        chk("single_lat1", res_v, 0);
        step();
        chk("single_resv", res_v, 1);
        chk("single_thr", res_thr, 2);
        chk("single_taken", res_taken, 1);
        chk("single_tgt", res_tgt, 32'h2000_0042);
        step();
        chk("single_drain", res_v, 0);

        // Rotation: pointer sits at 3 after the single grant to thread 2.
        set_thr(0, 3'd0, 32'd1, 32'd2, 32'h1000);
        set_thr(1, 3'd6, 32'd5, 32'd6, 32'h1010);
        set_thr(2, 3'd3, -32'sd1, -32'sd2, 32'h1020);
        set_thr(3, 3'd7, 32'd7, 32'd7, 32'h1030);
        for (int k = 0; k < 8; k++) begin
            req = (k < 5) ? 4'hF : 4'h0;
            #1;
            chk("rot_gnt", gnt, (k < 5) ? (4'b0001 << ((3 + k) % 4)) : 4'b0000);
            chk("rot_resv", res_v, (k >= 2 && k <= 6) ? 1 : 0);
            if (k >= 2 && k <= 6) begin
                chk("rot_thr", res_thr, (1 + k) % 4);
                chk("rot_taken", res_taken, rot_taken[(1 + k) % 4]);
                chk("rot_tgt", res_tgt, 32'h1000 + 16 * ((1 + k) % 4));
            end
            step();
        end

        // Backpressure: fill S1 (thread 1) and output (thread 0), stall 3 cycles.
        rdy = 1'b0;
        req = 4'b0011;
        #1;
        chk("bp_gnt0", gnt, 4'b0001);
        step();
        req = 4'b0010;
        #1;
        chk("bp_gnt1", gnt, 4'b0010);
        step();
        req = 4'b1000;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("bp_stall_gnt", gnt, 0);
            chk("bp_stall_resv", res_v, 1);
            chk("bp_stall_thr", res_thr, 0);
            chk("bp_stall_tgt", res_tgt, 32'h1000);
            step();
        end
        req = '0;
        rdy = 1'b1;
        #1;
        chk("bp_rel_thr0", res_thr, 0);
        chk("bp_rel_v0", res_v, 1);
        step();
        chk("bp_rel_v1", res_v, 1);
        chk("bp_rel_thr1", res_thr, 1);
        chk("bp_rel_tgt1", res_tgt, 32'h1010);
        step();
        chk("bp_drain", res_v, 0);

        // Flush of the stalled output entry (thread 0), thread 1 still in S1.
        rdy = 1'b0;
        req = 4'b0011;
        #1;
        chk("fl_gnt0", gnt, 4'b0001);
        step();
        req = 4'b0010;
        #1;
        chk("fl_gnt1", gnt, 4'b0010);
        step();
        req = '0;
        flush = 4'b0001;
        #1;
        chk("fl_pre_v", res_v, 1);
        chk("fl_pre_thr", res_thr, 0);
        step();
        flush = '0;
        chk("fl_drop", res_v, 0);
        step();
        chk("fl_t1_v", res_v, 1);
        chk("fl_t1_thr", res_thr, 1);
        chk("fl_t1_taken", res_taken, 0);
        rdy = 1'b1;
        step();
        chk("fl_drain", res_v, 0);

        // Flush of S1 in the same cycle it advances; same-cycle grant suppressed.
        req = 4'b0100;
        #1;
        chk("fa_gnt", gnt, 4'b0100);
        step();
        flush = 4'b0100;
        #1;
        chk("fa_supp", gnt, 0);
        step();
        flush = '0;
        req = '0;
        chk("fa_out", res_v, 0);
        step();
        chk("fa_out2", res_v, 0);

        // Condition coverage with a = b = 0x80000000, thread 0 alone every cycle.
        a[31:0] = 32'h8000_0000;
        b[31:0] = 32'h8000_0000;
        for (int k = 0; k < 11; k++) begin
            if (k < 9) begin
                ir[39:0]  = (k < 8) ? mk_ir(OPC_BCC, 3'(k)) : mk_ir(6'h1c, 3'd6);
                tgt[31:0] = 32'h3000_0000 + k;
                req       = 4'b0001;
            end else begin
                req = '0;
            end
            #1;
            chk("cc_gnt", gnt, (k < 9) ? 4'b0001 : 4'b0000);
            if (k >= 2) begin
                chk("cc_v", res_v, 1);
                chk("cc_taken", res_taken, cc_exp[k - 2]);
                chk("cc_tgt", res_tgt, 32'h3000_0000 + k - 2);
            end
            step();
        end
        step();

        // Asynchronous reset mid-stream.
        req = 4'hF;
        #1;
        chk("mr_gnt", gnt, 4'b0010);
        step();
        step();
        #2;
        chk("mr_pre_v", res_v, 1);
        chk("mr_pre_thr", res_thr, 1);
        rst = 1'b1;
        #1;
        chk("mr_v", res_v, 0);
        chk("mr_gnt_rst", gnt, 0);
        req = '0;
        step();
        rst = 1'b0;
        #1;
        chk("mr_v_rel", res_v, 0);
        step();
        chk("mr_nores", res_v, 0);
        req = 4'hF;
        #1;
        chk("mr_ptr", gnt, 4'b0001);
        step();
        req = '0;
        step();
        chk("mr_res_v", res_v, 1);
        chk("mr_res_thr", res_thr, 0);

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end

endmodule
